// File: rtl/bpm_pkg.sv
// Shared constants, FSM state type and helpers for the peak/BPM detector.
package bpm_pkg;

  localparam int unsigned WIDTH_DEF   = 10;
  localparam int unsigned FS_HZ_DEF   = 100;
  localparam int unsigned MIN_IV_DEF  = 30;
  localparam int unsigned MAX_IV_DEF  = 300;
  localparam int          THR_MIN_DEF = 16;
  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned DIV_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_OUT
  } div_state_e;

  function automatic logic [7:0] sat_u8(input logic [DIV_W-1:0] v);
    return (v > DIV_W'(255)) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/peak_bpm_detector_if.sv
// Sample stream in, beat/heart-rate results out.
interface peak_bpm_detector_if
  import bpm_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEF
);

  logic                    en;
  logic                    valid_in;
  logic signed [Width-1:0] ppg_in;
  logic                    beat;
  logic [7:0]              bpm;
  logic                    bpm_valid;
  logic                    no_signal;

  modport master (
    output en, valid_in, ppg_in,
    input  beat, bpm, bpm_valid, no_signal
  );

  modport slave (
    input  en, valid_in, ppg_in,
    output beat, bpm, bpm_valid, no_signal
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done pulses once
// the cycle after the last bit has been produced.
module seq_divider
  import bpm_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [W-1:0]  rem_in, quo_in, dvs_in;
  logic [CW-1:0] left_q, left_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          load;
  logic [W:0]    trial;

  // The first quotient bit is produced on the start edge itself, so the
  // whole division occupies exactly W edges.
  always_comb begin
    load   = start && !busy_q;
    rem_in = load ? '0       : rem_q;
    quo_in = load ? dividend : quo_q;
    dvs_in = load ? divisor  : dvs_q;
    trial  = {rem_in, quo_in[W-1]};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    left_d = left_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (busy_q || load) begin
      dvs_d = dvs_in;
      if (trial >= {1'b0, dvs_in}) begin
        rem_d = trial[W-1:0] - dvs_in;
        quo_d = {quo_in[W-2:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        quo_d = {quo_in[W-2:0], 1'b0};
      end
      if (load) begin
        busy_d = 1'b1;
        left_d = CW'(W - 1);
      end else if (left_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        left_d = '0;
      end else begin
        left_d = left_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      left_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      left_q <= left_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/peak_bpm_detector.sv
// Peak picker on the filtered PPG stream; converts the peak-to-peak interval
// into beats per minute with a sequential divider.
module peak_bpm_detector
  import bpm_pkg::*;
#(
  parameter int unsigned Width   = WIDTH_DEF,
  parameter int unsigned FS_HZ   = FS_HZ_DEF,
  parameter int unsigned MIN_IV  = MIN_IV_DEF,
  parameter int unsigned MAX_IV  = MAX_IV_DEF,
  parameter int          THR_MIN = THR_MIN_DEF
) (
  input logic                clk,
  input logic                rst,
  peak_bpm_detector_if.slave bus
);

  localparam logic [DIV_W-1:0]        NUM       = DIV_W'(SEC_PER_MIN * FS_HZ);
  localparam logic signed [Width-1:0] THR_FLOOR = Width'(THR_MIN);

  div_state_e              state_q, state_d;
  logic signed [Width-1:0] prev_q, prev_d, last_amp_q, last_amp_d;
  logic signed [Width-1:0] half_amp, thr;
  logic [DIV_W-1:0]        cnt_q, cnt_d, interval, div_quo;
  logic                    rising_q, rising_d, have_prev_q, have_prev_d;
  logic                    beat_q, beat_d, bpm_valid_q, bpm_valid_d;
  logic                    no_signal_q, no_signal_d;
  logic [7:0]              bpm_q, bpm_d;
  logic                    sample, cand, peak_ok, timeout, div_start, div_done;

  seq_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (NUM),
    .divisor  (interval),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    sample    = bus.en && bus.valid_in;
    half_amp  = last_amp_q >>> 1;
    thr       = (half_amp > THR_FLOOR) ? half_amp : THR_FLOOR;
    interval  = cnt_q + DIV_W'(1);
    cand      = sample && rising_q && (bus.ppg_in < prev_q);
    peak_ok   = cand && (prev_q >= thr) &&
                (!have_prev_q || (interval >= DIV_W'(MIN_IV)));
    timeout   = sample && !peak_ok && (cnt_q == DIV_W'(MAX_IV - 1));
    div_start = peak_ok && have_prev_q && (state_q == S_IDLE);

    prev_d      = prev_q;
    rising_d    = rising_q;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;
    last_amp_d  = last_amp_q;
    no_signal_d = no_signal_q;
    bpm_d       = bpm_q;
    bpm_valid_d = 1'b0;
    beat_d      = peak_ok;
    state_d     = state_q;

    if (sample) begin
      prev_d = bus.ppg_in;
      if (bus.ppg_in > prev_q) rising_d = 1'b1;
      else if (cand)           rising_d = 1'b0;
      if (peak_ok) begin
        cnt_d       = '0;
        have_prev_d = 1'b1;
        last_amp_d  = prev_q;
        no_signal_d = 1'b0;
      end else if (cnt_q < DIV_W'(MAX_IV)) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // Peaks arriving outside IDLE still beat but never restart the divider.
    unique case (state_q)
      S_IDLE: if (div_start) state_d = S_DIV;
      S_DIV:  if (div_done)  state_d = S_OUT;
      S_OUT: begin
        bpm_d       = sat_u8(div_quo);
        bpm_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      have_prev_d = 1'b0;
      last_amp_d  = '0;
      no_signal_d = 1'b1;
      bpm_d       = '0;
      bpm_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      rising_q    <= 1'b0;
      cnt_q       <= '0;
      have_prev_q <= 1'b0;
      last_amp_q  <= '0;
      beat_q      <= 1'b0;
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
      no_signal_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      rising_q    <= rising_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
      last_amp_q  <= last_amp_d;
      beat_q      <= beat_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      no_signal_q <= no_signal_d;
    end
  end

  assign bus.beat      = beat_q;
  assign bus.bpm       = bpm_q;
  assign bus.bpm_valid = bpm_valid_q;
  assign bus.no_signal = no_signal_q;

endmodule

// File: tb/tb_peak_bpm_detector.sv
// Directed bench: triangle pulse trains with hand-computed beat/BPM results.
module tb_peak_bpm_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;

  peak_bpm_detector_if #(.Width(10)) bus ();

  peak_bpm_detector #(
    .Width   (10),
    .FS_HZ   (100),
    .MIN_IV  (30),
    .MAX_IV  (300),
    .THR_MIN (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int beat_total = 0, bv_total = 0, beat_cyc = 0, bv_gap = 0, bv_val = 0;
  int base_beat = 0, base_bv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.bpm_valid) begin
      bv_total = bv_total + 1;
      bv_gap   = cyc - beat_cyc;
      bv_val   = int'(bus.bpm);
    end
    if (bus.beat) begin
      beat_total = beat_total + 1;
      beat_cyc   = cyc;
    end
  end

  task automatic check(input string tag, input int act, input int exp_v);
    n_checks = n_checks + 1;
    if (act == exp_v) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
  endtask

  // Symmetric spike of half-width 10 samples centred on c.
  function automatic int tri_v(input int i, input int c, input int amp);
    int d;
    d = (i > c) ? i - c : c - i;
    return (d > 10) ? 0 : amp - (amp / 10) * d;
  endfunction

  task automatic drive(input int v, input logic e = 1'b1);
    @(negedge clk);
    bus.en       = e;
    bus.valid_in = 1'b1;
    bus.ppg_in   = v[9:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.en       = 1'b1;
    bus.ppg_in   = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    base_beat = beat_total;
    base_bv   = bv_total;
  endtask

  task automatic run_period(input string tag, input int p, input int exp_bpm);
    do_reset();
    for (int i = 0; i < 3 * p; i++) drive(tri_v(i % p, 10, 200));
    idle(25);
    check({tag, "_beats"}, beat_total - base_beat, 3);
    check({tag, "_bvcnt"}, bv_total - base_bv, 2);
    check({tag, "_bpm"}, bv_val, exp_bpm);
    check({tag, "_gap"}, bv_gap, 17);
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.valid_in = 1'b0;
    bus.ppg_in   = '0;

    do_reset();
    check("rst_beat", int'(bus.beat), 0);
    check("rst_bpm", int'(bus.bpm), 0);
    check("rst_bpm_valid", int'(bus.bpm_valid), 0);
    check("rst_no_signal", int'(bus.no_signal), 1);

    run_period("p75", 75, 80);
    run_period("p60", 60, 100);
    run_period("p100", 100, 60);
    run_period("p30", 30, 200);

    // Spurious peak 20 samples after a beat must be ignored.
    do_reset();
    for (int i = 0; i < 120; i++)
      drive(tri_v(i, 10, 200) + tri_v(i, 30, 200) + tri_v(i, 85, 200));
    idle(25);
    check("extra_beats", beat_total - base_beat, 2);
    check("extra_bvcnt", bv_total - base_bv, 1);
    check("extra_bpm", bv_val, 80);

    // Low-amplitude peak below thr, then flat input until timeout.
    do_reset();
    for (int i = 0; i <= 385; i++)
      drive(tri_v(i, 10, 200) + tri_v(i, 85, 200) + tri_v(i, 160, 50));
    check("lowamp_beats", beat_total - base_beat, 2);
    check("pre_to_no_signal", int'(bus.no_signal), 0);
    check("pre_to_bpm", int'(bus.bpm), 80);
    check("pre_to_bvcnt", bv_total - base_bv, 1);
    drive(0);
    check("to_no_signal", int'(bus.no_signal), 1);
    for (int i = 387; i < 400; i++) drive(0);
    check("to_bpm", int'(bus.bpm), 0);
    check("to_bvcnt", bv_total - base_bv, 2);
    check("to_bv_val", bv_val, 0);

    // Reset 5 cycles after a beat aborts the division.
    do_reset();
    for (int i = 0; i <= 166; i++) drive(tri_v(i % 75, 10, 200));
    check("prerst_beats", beat_total - base_beat, 3);
    check("prerst_bpm", int'(bus.bpm), 80);
    check("prerst_no_signal", int'(bus.no_signal), 0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_beat", int'(bus.beat), 0);
    check("midrst_bpm", int'(bus.bpm), 0);
    check("midrst_bpm_valid", int'(bus.bpm_valid), 0);
    check("midrst_no_signal", int'(bus.no_signal), 1);
    @(negedge clk);
    rst = 1'b0;
    idle(30);
    check("midrst_bvcnt", bv_total - base_bv, 1);

    // en=0 pauses (one during counting, one during division) are invisible.
    do_reset();
    for (int i = 0; i < 110; i++) begin
      if (i == 40 || i == 88)
        for (int k = 0; k < 10; k++) drive(150, 1'b0);
      drive(tri_v(i % 75, 10, 200));
    end
    idle(25);
    check("en_beats", beat_total - base_beat, 2);
    check("en_bvcnt", bv_total - base_bv, 1);
    check("en_bpm", bv_val, 80);
    check("en_gap", bv_gap, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
